roi_color_accumulator: RTL and testbench

Per-frame region-of-interest colour classifier sitting between the OV7670 pixel stream (after RGB565 assembly and x/y counting) and the colour result manager. It classifies every in-ROI pixel as RED, GREEN, BLUE, WHITE or other, and accumulates saturating 16-bit counts per class. At each frame end it emits either a one-cycle `color_valid` pulse carrying the dominant colour and its pixel count, or a `white_detected` pulse, exactly once per frame.

---
 rtl/roi_color_accumulator.sv | 209 ++++++++++++++++++++
 tb/tb_roi_color_accumulator.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/roi_color_accumulator.sv
// roi_color_accumulator
// Classifies every in-ROI RGB565 pixel as RED/GREEN/BLUE/WHITE/other,
// keeps saturating per-class counts for the frame, and emits exactly one
// result pulse (colour or white) per completed frame.
// Stage 1 registers the pixel and the frame_start/frame_end events
// together, so the FSM below always sees events aligned with the pixel
// sitting in stage 1.
module roi_color_accumulator #(
  parameter int unsigned ROI_X0       = 280,
  parameter int unsigned ROI_X1       = 359,
  parameter int unsigned ROI_Y0       = 200,
  parameter int unsigned ROI_Y1       = 279,
  parameter logic [4:0]  CH_MIN       = 5'd8,
  parameter logic [4:0]  COLOR_MARGIN = 5'd4,
  parameter logic [4:0]  WHITE_TH     = 5'd20,
  parameter logic [15:0] COLOR_MIN    = 16'd100,
  parameter logic [15:0] WHITE_MIN    = 16'd3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pixel_valid,
  input  logic [15:0] pixel_data,
  input  logic [9:0]  pixel_x,
  input  logic [8:0]  pixel_y,
  input  logic        frame_start,
  input  logic        frame_end,
  output logic [1:0]  detected_color,
  output logic        color_valid,
  output logic [15:0] color_confidence,
  output logic        white_detected,
  output logic [15:0] dbg_white_count,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, ACCUM, DRAIN1, DRAIN2, DECIDE} state_t;

  localparam logic [1:0] COL_NONE  = 2'b00;
  localparam logic [1:0] COL_RED   = 2'b01;
  localparam logic [1:0] COL_GREEN = 2'b10;
  localparam logic [1:0] COL_BLUE  = 2'b11;

  // stage 1
  logic [4:0] r_q, g_q, b_q, r_d, g_d, b_d;
  logic       roi_q, roi_d, fs_q, fs_d, fe_q, fe_d;
  // stage 2 / control
  state_t      state_q, state_d;
  logic        pend_q, pend_d;
  logic [15:0] cnt_r_q, cnt_g_q, cnt_b_q, cnt_w_q;
  logic [15:0] cnt_r_d, cnt_g_d, cnt_b_d, cnt_w_d;
  // registered outputs
  logic [1:0]  det_q, det_d;
  logic        cv_q, cv_d, wd_q, wd_d;
  logic [15:0] conf_q, conf_d, wdbg_q, wdbg_d;

  // green's LSB does not take part in classification
  logic unused_g_lsb;
  assign unused_g_lsb = pixel_data[5];

  // Stage 1 input capture: channel split and ROI window test.
  always_comb begin
    r_d   = pixel_data[15:11];
    g_d   = pixel_data[10:6];
    b_d   = pixel_data[4:0];
    roi_d = pixel_valid &&
            (pixel_x >= 10'(ROI_X0)) && (pixel_x <= 10'(ROI_X1)) &&
            (pixel_y >= 9'(ROI_Y0))  && (pixel_y <= 9'(ROI_Y1));
    fs_d  = frame_start;
    fe_d  = frame_end;
  end

  // Pixel class of the stage-1 pixel; 6-bit maths keeps channel+margin exact.
  logic [5:0] r6, g6, b6, m6;
  logic       is_white, is_red, is_green, is_blue;
  always_comb begin
    r6 = {1'b0, r_q};
    g6 = {1'b0, g_q};
    b6 = {1'b0, b_q};
    m6 = {1'b0, COLOR_MARGIN};
    is_white = (r6 >= {1'b0, WHITE_TH}) && (g6 >= {1'b0, WHITE_TH}) &&
               (b6 >= {1'b0, WHITE_TH});
    is_red   = !is_white && (r6 >= {1'b0, CH_MIN}) &&
               (r6 >= g6 + m6) && (r6 >= b6 + m6);
    is_green = !is_white && !is_red && (g6 >= {1'b0, CH_MIN}) &&
               (g6 >= r6 + m6) && (g6 >= b6 + m6);
    is_blue  = !is_white && !is_red && !is_green && (b6 >= {1'b0, CH_MIN}) &&
               (b6 >= r6 + m6) && (b6 >= g6 + m6);
  end

  // Dominant colour of the frame; ties go RED over GREEN over BLUE.
  logic [15:0] max_cnt;
  logic [1:0]  win;
  always_comb begin
    if (cnt_r_q >= cnt_g_q && cnt_r_q >= cnt_b_q) begin
      max_cnt = cnt_r_q;
      win     = COL_RED;
    end else if (cnt_g_q >= cnt_b_q) begin
      max_cnt = cnt_g_q;
      win     = COL_GREEN;
    end else begin
      max_cnt = cnt_b_q;
      win     = COL_BLUE;
    end
  end

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Frame FSM, counter update and result formation.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cnt_r_d = cnt_r_q;
    cnt_g_d = cnt_g_q;
    cnt_b_d = cnt_b_q;
    cnt_w_d = cnt_w_q;
    det_d   = det_q;
    conf_d  = conf_q;
    wdbg_d  = wdbg_q;
    cv_d    = 1'b0;
    wd_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (fs_q) begin
          cnt_r_d = '0; cnt_g_d = '0; cnt_b_d = '0; cnt_w_d = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (fs_q && !fe_q) begin
          // abandon the partial frame and restart from zero
          cnt_r_d = '0; cnt_g_d = '0; cnt_b_d = '0; cnt_w_d = '0;
        end else begin
          if (roi_q) begin
            if (is_white) cnt_w_d = sat_inc(cnt_w_q);
            if (is_red)   cnt_r_d = sat_inc(cnt_r_q);
            if (is_green) cnt_g_d = sat_inc(cnt_g_q);
            if (is_blue)  cnt_b_d = sat_inc(cnt_b_q);
          end
          if (fe_q) begin
            state_d = DRAIN1;
            pend_d  = fs_q;
          end
        end
      end
      DRAIN1: begin
        if (fs_q) pend_d = 1'b1;
        state_d = DRAIN2;
      end
      DRAIN2: begin
        if (fs_q) pend_d = 1'b1;
        state_d = DECIDE;
      end
      DECIDE: begin
        wdbg_d = cnt_w_q;
        if (max_cnt >= COLOR_MIN) begin
          cv_d   = 1'b1;
          det_d  = win;
          conf_d = max_cnt;
        end else if (cnt_w_q >= WHITE_MIN) begin
          wd_d = 1'b1;
        end else begin
          cv_d   = 1'b1;
          det_d  = COL_NONE;
          conf_d = max_cnt;
        end
        if (pend_q || fs_q) begin
          cnt_r_d = '0; cnt_g_d = '0; cnt_b_d = '0; cnt_w_d = '0;
          pend_d  = 1'b0;
          state_d = ACCUM;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All state, async active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0; g_q <= '0; b_q <= '0;
      roi_q <= 1'b0; fs_q <= 1'b0; fe_q <= 1'b0;
      state_q <= IDLE;
      pend_q  <= 1'b0;
      cnt_r_q <= '0; cnt_g_q <= '0; cnt_b_q <= '0; cnt_w_q <= '0;
      det_q <= COL_NONE; cv_q <= 1'b0; wd_q <= 1'b0;
      conf_q <= '0; wdbg_q <= '0;
    end else begin
      r_q <= r_d; g_q <= g_d; b_q <= b_d;
      roi_q <= roi_d; fs_q <= fs_d; fe_q <= fe_d;
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_r_q <= cnt_r_d; cnt_g_q <= cnt_g_d;
      cnt_b_q <= cnt_b_d; cnt_w_q <= cnt_w_d;
      det_q <= det_d; cv_q <= cv_d; wd_q <= wd_d;
      conf_q <= conf_d; wdbg_q <= wdbg_d;
    end
  end

  assign detected_color   = det_q;
  assign color_valid      = cv_q;
  assign color_confidence = conf_q;
  assign white_detected   = wd_q;
  assign dbg_white_count  = wdbg_q;
  assign busy             = (state_q == DRAIN1) || (state_q == DRAIN2) ||
                            (state_q == DECIDE);

endmodule

// File: tb/tb_roi_color_accumulator.sv
// Directed frames with a scoreboard of expected result pulses.
module tb_roi_color_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        pixel_valid;
  logic [15:0] pixel_data;
  logic [9:0]  pixel_x;
  logic [8:0]  pixel_y;
  logic        frame_start, frame_end;
  logic [1:0]  detected_color;
  logic        color_valid, white_detected, busy;
  logic [15:0] color_confidence, dbg_white_count;

  roi_color_accumulator dut (
    .clk(clk), .reset(reset), .pixel_valid(pixel_valid), .pixel_data(pixel_data),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_start(frame_start),
    .frame_end(frame_end), .detected_color(detected_color),
    .color_valid(color_valid), .color_confidence(color_confidence),
    .white_detected(white_detected), .dbg_white_count(dbg_white_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          white;
    logic [1:0]  col;
    logic [15:0] conf;
    logic [15:0] wc;
    int          at;
  } exp_t;
  exp_t sbq[$];
  logic [1:0]  m_col  = 2'd0;
  logic [15:0] m_conf = 16'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse monitor: every result pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (color_valid || white_detected) begin
      if (sbq.size() == 0) begin
        check("unexpected_pulse", {30'd0, color_valid, white_detected}, 32'd0);
      end else begin
        e = sbq.pop_front();
        check("pulse_kind", {30'd0, color_valid, white_detected}, e.white ? 32'd1 : 32'd2);
        check("pulse_cycle", cyc, e.at);
        check("detected_color", {30'd0, detected_color}, {30'd0, e.col});
        check("color_confidence", {16'd0, color_confidence}, {16'd0, e.conf});
        check("dbg_white_count", {16'd0, dbg_white_count}, {16'd0, e.wc});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pix(input int mode, input int x, input int y);
    bit in_roi;
    in_roi = (x >= 280 && x <= 359 && y >= 200 && y <= 279);
    case (mode)
      0: return 16'hF800;
      1: return 16'hFFFF;
      2: return in_roi ? 16'h07E0 : 16'h001F;
      3: return in_roi ? 16'h8410 : 16'h001F;
      4: return (in_roi && (x == 280 || x == 359 || y == 200 || y == 279)) ? 16'h07E0 : 16'h8410;
      5: return in_roi ? ((y < 240) ? 16'hF800 : 16'h07E0) : 16'h8410;
      6: return (in_roi && y == 200 && x < 330) ? 16'h001F : 16'h8410;
      default: return 16'h001F;
    endcase
  endfunction

  // Drive one frame; frame_end rides on the last pixel. Pushes the expected result.
  task automatic frame(input int mode, input int x0, input int x1, input int y0, input int y1,
                       input bit do_start, input bit ew, input logic [1:0] ecol,
                       input logic [15:0] econf, input logic [15:0] ewc);
    exp_t e;
    if (do_start) begin
      frame_start = 1'b1; tick();
      frame_start = 1'b0; tick();
    end
    for (int y = y0; y <= y1; y++) begin
      for (int x = x0; x <= x1; x++) begin
        pixel_valid = 1'b1;
        pixel_data  = pix(mode, x, y);
        pixel_x     = 10'(x);
        pixel_y     = 9'(y);
        if (x == x1 && y == y1) begin
          frame_end = 1'b1;
          if (ew) begin
            e = '{1'b1, m_col, m_conf, ewc, cyc + 5};
          end else begin
            m_col = ecol; m_conf = econf;
            e = '{1'b0, ecol, econf, ewc, cyc + 5};
          end
          sbq.push_back(e);
        end
        tick();
      end
    end
    pixel_valid = 1'b0;
    frame_end   = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    for (int i = 0; i < 20 && sbq.size() != 0; i++) tick();
    check(tag, sbq.size(), 32'd0);
    sbq.delete();
    tick();
  endtask

  initial begin
    reset = 1'b1; pixel_valid = 1'b0; pixel_data = '0; pixel_x = '0; pixel_y = '0;
    frame_start = 1'b0; frame_end = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_color", {30'd0, detected_color}, 32'd0);
    check("rst_conf", {16'd0, color_confidence}, 32'd0);
    check("rst_valid", {30'd0, color_valid, white_detected}, 32'd0);
    check("rst_wdbg", {16'd0, dbg_white_count}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // red frame, also watch busy through the drain
    frame(0, 278, 361, 198, 281, 1, 0, 2'd1, 16'd6400, 16'd0);
    tick();
    check("busy_drain", {31'd0, busy}, 32'd1);
    wait_result("red_timeout");
    check("busy_idle", {31'd0, busy}, 32'd0);

    frame(1, 278, 361, 198, 281, 1, 1, 2'd0, 16'd0, 16'd6400);
    wait_result("white_timeout");
    check("hold_color", {30'd0, detected_color}, 32'd1);
    check("hold_conf", {16'd0, color_confidence}, 32'd6400);

    frame(2, 278, 361, 198, 281, 1, 0, 2'd2, 16'd6400, 16'd0);
    wait_result("outside_timeout");
    frame(3, 278, 361, 198, 281, 1, 0, 2'd0, 16'd0, 16'd0);
    wait_result("leak_timeout");
    frame(4, 278, 361, 198, 281, 1, 0, 2'd2, 16'd316, 16'd0);
    wait_result("edge_timeout");
    frame(5, 278, 361, 198, 281, 1, 0, 2'd1, 16'd3200, 16'd0);
    wait_result("tie_timeout");
    frame(6, 278, 361, 198, 281, 1, 0, 2'd0, 16'd50, 16'd0);
    wait_result("below_timeout");

    // frame_start lands while the FSM is draining; the next frame starts from zero
    frame(7, 280, 359, 200, 201, 1, 0, 2'd3, 16'd160, 16'd0);
    tick();
    frame_start = 1'b1; tick();
    frame_start = 1'b0;
    wait_result("pendA_timeout");
    frame(7, 280, 359, 200, 200, 0, 0, 2'd0, 16'd80, 16'd0);
    wait_result("pendB_timeout");

    // reset in the middle of a frame: nothing comes out afterwards
    frame_start = 1'b1; tick();
    frame_start = 1'b0; tick();
    for (int i = 0; i < 200; i++) begin
      pixel_valid = 1'b1; pixel_data = 16'hF800;
      pixel_x = 10'(280 + (i % 80)); pixel_y = 9'(200 + i / 80);
      tick();
    end
    pixel_valid = 1'b0;
    reset = 1'b1; tick(); tick();
    reset = 1'b0; tick();
    check("mid_rst_color", {30'd0, detected_color}, 32'd0);
    check("mid_rst_conf", {16'd0, color_confidence}, 32'd0);
    check("mid_rst_wdbg", {16'd0, dbg_white_count}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    frame_end = 1'b1; tick();
    frame_end = 1'b0;
    repeat (12) tick();
    check("mid_rst_sbq", sbq.size(), 32'd0);
    check("mid_rst_busy_after", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
